// File: rtl/dmem_responder_if.sv
// dmem_responder_if
//   Request/response bundle between the core's data-memory port and the
//   memory-side responder.
//   Request  : req_valid, req_ready, req_we, req_funct3, req_addr, req_wdata
//   Response : resp_valid (one-cycle pulse), resp_rdata, resp_err
//   master  = requester (core side), slave = responder (memory side).
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder
//   Memory-side responder for the core's data-memory port. Accepts a single
//   load/store at a time, spends WAIT_CYCLES extra cycles in WAIT, commits
//   the access on the WAIT->RESP edge and returns a one-cycle response.
//   Byte/half/word accesses follow RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW rules.
// Ports
//   clk   : clock, rising edge
//   rst   : asynchronous, active-low reset (storage array is not cleared)
//   bus   : dmem_responder_if.slave (request handshake + response pulse)
// Parameters
//   DEPTH       : number of 32-bit words (power of two, >= 4)
//   WAIT_CYCLES : extra cycles spent in WAIT before commit (0..15)
module dmem_responder #(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input logic             clk,
  input logic             rst,
  dmem_responder_if.slave bus
);

  localparam int unsigned AW         = $clog2(DEPTH);
  localparam logic [29:0] WORD_LIMIT = 30'(DEPTH);
  localparam logic [3:0]  WAIT_LOAD  = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;

  logic [31:0] mem_q [DEPTH];

  logic          commit_s;
  logic          err_s;
  logic [AW-1:0] word_idx_s;
  logic [1:0]    lane_s;
  logic [31:0]   rd_word_s;
  logic [31:0]   load_data_s;
  logic          mem_we_s;
  logic [3:0]    mem_be_s;
  logic [31:0]   mem_wdata_s;

  // Any one of these makes the request an error: unknown funct3, store
  // with an unsigned-load encoding, misalignment, or word index past DEPTH.
  function automatic logic access_error(input logic        we,
                                        input logic [2:0]  funct3,
                                        input logic [31:0] addr);
    logic err;
    case (funct3)
      3'b000:  err = 1'b0;
      3'b001:  err = addr[0];
      3'b010:  err = (addr[1:0] != 2'b00);
      3'b100:  err = we;
      3'b101:  err = we | addr[0];
      default: err = 1'b1;
    endcase
    err = err | (addr[31:2] >= WORD_LIMIT);
    return err;
  endfunction

  // Lane select and sign/zero extension of a loaded word.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [2:0]  funct3,
                                              input logic [1:0]  lane);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (funct3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b010:  r = word;
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Byte strobes for a store; halfwords use lanes {addr[1],0} and {addr[1],1}.
  function automatic logic [3:0] store_strobe(input logic [2:0] funct3,
                                              input logic [1:0] lane);
    logic [3:0] be;
    case (funct3)
      3'b000:  be = 4'b0001 << lane;
      3'b001:  be = lane[1] ? 4'b1100 : 4'b0011;
      3'b010:  be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Right-aligned store data replicated so every lane carries its byte.
  function automatic logic [31:0] store_lanes(input logic [31:0] wdata,
                                              input logic [2:0]  funct3);
    logic [31:0] d;
    case (funct3)
      3'b000:  d = {4{wdata[7:0]}};
      3'b001:  d = {2{wdata[15:0]}};
      3'b010:  d = wdata;
      default: d = 32'd0;
    endcase
    return d;
  endfunction

  // Decode of the latched request used at commit.
  always_comb begin
    err_s       = access_error(we_q, funct3_q, addr_q);
    word_idx_s  = addr_q[AW+1:2];
    lane_s      = addr_q[1:0];
    rd_word_s   = mem_q[word_idx_s];
    load_data_s = load_extend(rd_word_s, funct3_q, lane_s);
    mem_be_s    = store_strobe(funct3_q, lane_s);
    mem_wdata_s = store_lanes(wdata_q, funct3_q);
  end

  // Next-state, request latch and response computation.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    commit_s     = 1'b0;
    case (state_q)
      S_IDLE: begin
        // req_ready is high throughout IDLE, so req_valid alone accepts.
        if (bus.req_valid) begin
          we_d     = bus.req_we;
          funct3_d = bus.req_funct3;
          addr_d   = bus.req_addr;
          wdata_d  = bus.req_wdata;
          cnt_d    = WAIT_LOAD;
          state_d  = S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          commit_s     = 1'b1;
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = err_s;
          if (err_s || we_q) begin
            resp_rdata_d = 32'd0;
          end else begin
            resp_rdata_d = load_data_s;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d      = S_IDLE;
        resp_valid_d = 1'b0;
        resp_rdata_d = 32'd0;
        resp_err_d   = 1'b0;
      end
      default: begin
        state_d      = S_IDLE;
        resp_valid_d = 1'b0;
        resp_rdata_d = 32'd0;
        resp_err_d   = 1'b0;
      end
    endcase
  end

  // Stores only reach the array on an error-free commit.
  always_comb begin
    mem_we_s = commit_s & we_q & ~err_s;
  end

  // FSM, request latch and registered response outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      we_q         <= 1'b0;
      funct3_q     <= 3'd0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      funct3_q     <= funct3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Byte-lane storage write; no reset so committed data survives rst.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_be_s[i]) begin
          mem_q[word_idx_s][8*i +: 8] <= mem_wdata_s[8*i +: 8];
        end
      end
    end
  end

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
//   Three responders share one clock: WAIT_CYCLES = 0, 1 and 4. Requests are
//   routed to one of them by sel. The WAIT_CYCLES=1 instance is checked
//   against a byte-addressed reference memory under directed and random
//   traffic; the other two cover back-to-back throughput and mid-WAIT reset.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 64;
  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        rst4_n;
  logic        rst4_line;
  logic [1:0]  sel;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        ready_m;
  logic        rv_m;
  logic [31:0] rdata_m;
  logic        err_m;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0]  bmem [4*DEPTH];
  logic [31:0] last_rdata;
  logic        last_err;

  dmem_responder_if bus0 ();
  dmem_responder_if bus1 ();
  dmem_responder_if bus4 ();

  assign bus0.req_valid  = req_valid & (sel == 2'd0);
  assign bus1.req_valid  = req_valid & (sel == 2'd1);
  assign bus4.req_valid  = req_valid & (sel == 2'd2);
  assign bus0.req_we     = req_we;
  assign bus1.req_we     = req_we;
  assign bus4.req_we     = req_we;
  assign bus0.req_funct3 = req_funct3;
  assign bus1.req_funct3 = req_funct3;
  assign bus4.req_funct3 = req_funct3;
  assign bus0.req_addr   = req_addr;
  assign bus1.req_addr   = req_addr;
  assign bus4.req_addr   = req_addr;
  assign bus0.req_wdata  = req_wdata;
  assign bus1.req_wdata  = req_wdata;
  assign bus4.req_wdata  = req_wdata;
  assign rst4_line       = rst_n & rst4_n;

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (.clk(clk), .rst(rst_n),     .bus(bus0));
  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(1)) dut1 (.clk(clk), .rst(rst_n),     .bus(bus1));
  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(4)) dut4 (.clk(clk), .rst(rst4_line), .bus(bus4));

  // Observe whichever responder is selected.
  always_comb begin
    case (sel)
      2'd0: begin
        ready_m = bus0.req_ready; rv_m = bus0.resp_valid;
        rdata_m = bus0.resp_rdata; err_m = bus0.resp_err;
      end
      2'd1: begin
        ready_m = bus1.req_ready; rv_m = bus1.resp_valid;
        rdata_m = bus1.resp_rdata; err_m = bus1.resp_err;
      end
      default: begin
        ready_m = bus4.req_ready; rv_m = bus4.resp_valid;
        rdata_m = bus4.resp_rdata; err_m = bus4.resp_err;
      end
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: observed %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic int w_of(input logic [1:0] s);
    if (s == 2'd0) return 0;
    else if (s == 2'd1) return 1;
    else return 4;
  endfunction

  // Reference: byte-addressed memory, access size from funct3, rules applied directly.
  task automatic ref_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, output logic err, output logic [31:0] rdata);
    int unsigned size;
    bit          sgn;
    logic [31:0] v;
    size = 0;
    sgn  = 1'b0;
    case (f3)
      3'd0:    begin size = 1; sgn = 1'b1; end
      3'd1:    begin size = 2; sgn = 1'b1; end
      3'd2:    size = 4;
      3'd4:    size = 1;
      3'd5:    size = 2;
      default: size = 0;
    endcase
    err = 1'b0;
    if (size == 0) err = 1'b1;
    else if ((addr % size) != 0) err = 1'b1;
    if ((addr >> 2) >= DEPTH) err = 1'b1;
    if (we && (f3 == 3'd4 || f3 == 3'd5)) err = 1'b1;
    rdata = 32'd0;
    if (!err && we) begin
      for (int i = 0; i < int'(size); i++) bmem[addr + 32'(i)] = wdata[8*i +: 8];
    end else if (!err) begin
      v = 32'd0;
      for (int i = 0; i < int'(size); i++) v[8*i +: 8] = bmem[addr + 32'(i)];
      if (sgn && size < 4 && v[8*size-1]) begin
        for (int i = int'(size); i < 4; i++) v[8*i +: 8] = 8'hFF;
      end
      rdata = v;
    end
  endtask

  // One request on the selected responder: handshake, latency, single-cycle pulse.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata, output logic err);
    int lat;
    bit seen;
    lat  = 0;
    seen = 1'b0;
    rdata = 32'd0;
    err   = 1'b0;
    @(negedge clk);
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    chk("ready_idle", 32'(ready_m), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("ready_after_accept", 32'(ready_m), 32'd0);
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (rv_m) begin
        lat  = c;
        seen = 1'b1;
        break;
      end
    end
    chk("resp_seen", 32'(seen), 32'd1);
    if (seen) begin
      chk("latency", 32'(lat), 32'(w_of(sel) + 1));
      chk("ready_in_resp", 32'(ready_m), 32'd0);
      rdata = rdata_m;
      err   = err_m;
      @(posedge clk); #1;
      chk("pulse_end_valid", 32'(rv_m), 32'd0);
      chk("pulse_end_rdata", rdata_m, 32'd0);
      chk("pulse_end_err", 32'(err_m), 32'd0);
      chk("ready_back", 32'(ready_m), 32'd1);
    end
  endtask

  task automatic txn1(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata);
    logic [31:0] got_d, exp_d;
    logic        got_e, exp_e;
    sel = 2'd1;
    do_req(we, f3, addr, wdata, got_d, got_e);
    ref_access(we, f3, addr, wdata, exp_e, exp_d);
    chk($sformatf("err we=%0d f3=%0d a=%h", we, f3, addr), 32'(got_e), 32'(exp_e));
    chk($sformatf("rdata we=%0d f3=%0d a=%h", we, f3, addr), got_d, exp_d);
    last_rdata = got_d;
    last_err   = got_e;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic        e;
    int          pulses;
    int          last_pulse;
    logic        we_r;
    logic [2:0]  f3_r;
    logic [31:0] a_r;

    rst_n = 1'b0; rst4_n = 1'b1; sel = 2'd1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    repeat (3) @(posedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s); #1;
      chk("rst_ready", 32'(ready_m), 32'd1);
      chk("rst_valid", 32'(rv_m), 32'd0);
      chk("rst_rdata", rdata_m, 32'd0);
      chk("rst_err", 32'(err_m), 32'd0);
    end
    @(negedge clk); rst_n = 1'b1;

    // Fill every word so the reference memory is fully known.
    for (int w = 0; w < int'(DEPTH); w++) txn1(1'b1, F_W, 32'(4*w), $urandom);

    txn1(1'b1, F_W, 32'h10, 32'hDEADBEEF);
    txn1(1'b0, F_W, 32'h10, 32'd0);
    chk("lw_deadbeef", last_rdata, 32'hDEADBEEF);
    txn1(1'b1, F_W, 32'h20, 32'h11223344);
    txn1(1'b1, F_B, 32'h21, 32'h000000AA);
    txn1(1'b0, F_W, 32'h20, 32'd0);
    chk("sb_merge", last_rdata, 32'h1122AA44);
    txn1(1'b0, F_B, 32'h21, 32'd0);
    chk("lb_sign", last_rdata, 32'hFFFFFFAA);
    txn1(1'b0, F_BU, 32'h21, 32'd0);
    chk("lbu_zero", last_rdata, 32'h000000AA);
    txn1(1'b1, F_H, 32'h32, 32'h00008001);
    txn1(1'b0, F_H, 32'h32, 32'd0);
    chk("lh_sign", last_rdata, 32'hFFFF8001);
    txn1(1'b0, F_HU, 32'h32, 32'd0);
    chk("lhu_zero", last_rdata, 32'h00008001);
    txn1(1'b0, F_H, 32'h31, 32'd0);
    chk("lh_misalign_err", 32'(last_err), 32'd1);
    chk("lh_misalign_rdata", last_rdata, 32'd0);
    txn1(1'b1, F_W, 32'h06, 32'hFFFFFFFF);
    chk("sw_misalign_err", 32'(last_err), 32'd1);
    txn1(1'b0, F_W, 32'(4*DEPTH), 32'd0);
    chk("lw_range_err", 32'(last_err), 32'd1);
    txn1(1'b0, F_W, 32'h04, 32'd0);
    chk("lw_after_err", 32'(last_err), 32'd0);
    txn1(1'b0, 3'b011, 32'h08, 32'd0);
    chk("f3_011_err", 32'(last_err), 32'd1);
    txn1(1'b1, F_BU, 32'h08, 32'h55);
    chk("store_bu_err", 32'(last_err), 32'd1);

    for (int n = 0; n < 300; n++) begin
      we_r = 1'($urandom_range(0, 1));
      f3_r = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) < 8) a_r = 32'($urandom_range(0, 4*DEPTH-1));
      else if ($urandom_range(0, 1) == 0) a_r = 32'(4*DEPTH) + 32'($urandom_range(0, 255));
      else a_r = $urandom;
      txn1(we_r, f3_r, a_r, $urandom);
    end

    // Back-to-back loads with req_valid held high, WAIT_CYCLES=0.
    sel = 2'd0;
    do_req(1'b1, F_W, 32'h08, 32'hCAFEF00D, d, e);
    chk("b2b_store_err", 32'(e), 32'd0);
    @(negedge clk);
    req_we = 1'b0; req_funct3 = F_W; req_addr = 32'h08; req_valid = 1'b1;
    pulses = 0;
    last_pulse = -1;
    for (int cyc = 1; cyc <= 9; cyc++) begin
      @(posedge clk); #1;
      chk("b2b_valid", 32'(rv_m), 32'(cyc % 3 == 2));
      chk("b2b_ready", 32'(ready_m), 32'(cyc % 3 == 0));
      if (rv_m) begin
        pulses++;
        chk("b2b_rdata", rdata_m, 32'hCAFEF00D);
        if (last_pulse >= 0) chk("b2b_spacing", 32'(cyc - last_pulse), 32'd3);
        last_pulse = cyc;
      end
      if (cyc == 7) req_valid = 1'b0;
    end
    chk("b2b_pulses", 32'(pulses), 32'd3);

    // Reset during WAIT discards the uncommitted store, WAIT_CYCLES=4.
    sel = 2'd2;
    do_req(1'b1, F_W, 32'h40, 32'h0BADF00D, d, e);
    chk("pre_store_err", 32'(e), 32'd0);
    @(negedge clk);
    req_we = 1'b1; req_funct3 = F_W; req_addr = 32'h40; req_wdata = 32'h12345678;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("mid_wait_ready", 32'(ready_m), 32'd0);
    rst4_n = 1'b0; #1;
    chk("mid_rst_ready", 32'(ready_m), 32'd1);
    chk("mid_rst_valid", 32'(rv_m), 32'd0);
    chk("mid_rst_rdata", rdata_m, 32'd0);
    chk("mid_rst_err", 32'(err_m), 32'd0);
    repeat (2) begin
      @(posedge clk); #1;
      chk("in_rst_valid", 32'(rv_m), 32'd0);
    end
    @(negedge clk); rst4_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("no_resp_after_rst", 32'(rv_m), 32'd0);
    end
    do_req(1'b0, F_W, 32'h40, 32'd0, d, e);
    chk("post_rst_err", 32'(e), 32'd0);
    chk("post_rst_rdata", d, 32'h0BADF00D);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
